// File: rtl/decode_stage_param.sv
// Decode stage: register file with write-through bypass, immediate extension,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage_param #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned RS1_LSB     = 20,
  parameter int unsigned RS2_LSB     = 16,
  parameter int unsigned RD_LSB      = 4,
  parameter int unsigned CTRL_W      = 8,
  parameter int unsigned MEMREAD_BIT = 3,
  parameter int unsigned IMM0_W      = 16,
  parameter int unsigned IMM1_W      = 12,
  parameter int unsigned IMM2_W      = 20,
  parameter bit          ZERO_REG    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_valid,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [XLEN-1:0]    d_pc,
  input  logic [XLEN-1:0]    d_pc4,
  input  logic [CTRL_W-1:0]  d_ctrl,
  input  logic [1:0]         d_imm_sel,
  input  logic               d_uses_rs1,
  input  logic               d_uses_rs2,
  input  logic               wb_we,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               ex_stall,
  input  logic               flush,
  output logic               d_stall,
  output logic               e_valid,
  output logic [CTRL_W-1:0]  e_ctrl,
  output logic [XLEN-1:0]    e_rd1,
  output logic [XLEN-1:0]    e_rd2,
  output logic [XLEN-1:0]    e_imm,
  output logic [REG_AW-1:0]  e_rs1,
  output logic [REG_AW-1:0]  e_rs2,
  output logic [REG_AW-1:0]  e_rd,
  output logic [XLEN-1:0]    e_pc,
  output logic [XLEN-1:0]    e_pc4
);

  localparam int unsigned NREGS = 2 ** REG_AW;

  logic [XLEN-1:0]   rf [NREGS];
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   rd1, rd2, imm;
  logic              wr_en, rd_nz, hz;
  logic              unused_instr;

  assign rs1 = d_instr[RS1_LSB +: REG_AW];
  assign rs2 = d_instr[RS2_LSB +: REG_AW];
  assign rd  = d_instr[RD_LSB  +: REG_AW];
  assign unused_instr = ^d_instr;

  assign wr_en = wb_we & ~(ZERO_REG & (wb_rd == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Reads see a same-cycle writeback; hardwired zero overrides everything.
  always_comb begin
    rd1 = rf[rs1];
    if (wb_we && (wb_rd == rs1)) rd1 = wb_data;
    if (ZERO_REG && (rs1 == '0)) rd1 = '0;
  end

  always_comb begin
    rd2 = rf[rs2];
    if (wb_we && (wb_rd == rs2)) rd2 = wb_data;
    if (ZERO_REG && (rs2 == '0)) rd2 = '0;
  end

  always_comb begin
    imm = '0;
    case (d_imm_sel)
      2'd0:    imm = XLEN'($signed(d_instr[IMM0_W-1:0]));
      2'd1:    imm = XLEN'($signed(d_instr[IMM1_W-1:0]));
      2'd2:    imm = XLEN'($signed(d_instr[IMM2_W-1:0]));
      default: imm = XLEN'(d_instr[IMM0_W-1:0]);
    endcase
  end

  // Load in EX whose destination feeds decode: one bubble required.
  assign rd_nz = (e_rd != '0) | ~ZERO_REG;
  assign hz = d_valid & e_valid & e_ctrl[MEMREAD_BIT] & rd_nz &
              ((d_uses_rs1 & (rs1 == e_rd)) | (d_uses_rs2 & (rs2 == e_rd)));
  assign d_stall = (hz | ex_stall) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid <= 1'b0;
      e_ctrl  <= '0;
      e_rd1   <= '0;
      e_rd2   <= '0;
      e_imm   <= '0;
      e_rs1   <= '0;
      e_rs2   <= '0;
      e_rd    <= '0;
      e_pc    <= '0;
      e_pc4   <= '0;
    end else if (flush || (!ex_stall && hz)) begin
      e_valid <= 1'b0;
      e_ctrl  <= '0;
    end else if (!ex_stall) begin
      e_valid <= d_valid;
      e_ctrl  <= d_valid ? d_ctrl : '0;
      e_rd1   <= rd1;
      e_rd2   <= rd2;
      e_imm   <= imm;
      e_rs1   <= rs1;
      e_rs2   <= rs2;
      e_rd    <= rd;
      e_pc    <= d_pc;
      e_pc4   <= d_pc4;
    end
  end

endmodule

// File: tb/tb_decode_stage_param.sv
// Directed bench for decode_stage_param: capture vectors plus hazard, flush,
// stall and reset sequences.
module tb_decode_stage_param;

  logic        clk, rst;
  logic        d_valid;
  logic [31:0] d_instr, d_pc, d_pc4;
  logic [7:0]  d_ctrl;
  logic [1:0]  d_imm_sel;
  logic        d_uses_rs1, d_uses_rs2;
  logic        wb_we;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_stall, flush;
  logic        d_stall, e_valid;
  logic [7:0]  e_ctrl;
  logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pc4;
  logic [3:0]  e_rs1, e_rs2, e_rd;

  int checks = 0;
  int errors = 0;

  decode_stage_param dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc),
    .d_pc4(d_pc4), .d_ctrl(d_ctrl), .d_imm_sel(d_imm_sel),
    .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush),
    .d_stall(d_stall), .e_valid(e_valid), .e_ctrl(e_ctrl), .e_rd1(e_rd1),
    .e_rd2(e_rd2), .e_imm(e_imm), .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .e_pc(e_pc), .e_pc4(e_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [1:0]  sel;
    logic [7:0]  ctrl;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exp_valid;
    logic [7:0]  exp_ctrl;
    logic [31:0] exp_rd1, exp_rd2, exp_imm;
    logic [3:0]  exp_rs1, exp_rs2, exp_rd;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [7:0] ctrl,
                       input logic [1:0] sel, input logic u1, input logic u2);
    d_valid = v; d_instr = instr; d_ctrl = ctrl; d_imm_sel = sel;
    d_uses_rs1 = u1; d_uses_rs2 = u2;
  endtask

  initial begin
    // valid instr sel ctrl wb_we wb_rd wb_data | e_valid e_ctrl rd1 rd2 imm rs1 rs2 rd
    vecs[0] = '{1'b1, 32'h0050_8001, 2'd0, 8'h01, 1'b1, 4'd5, 32'hDEADBEEF,
                1'b1, 8'h01, 32'hDEADBEEF, 32'h0, 32'hFFFF8001, 4'd5, 4'd0, 4'd0};
    vecs[1] = '{1'b1, 32'h0055_8001, 2'd3, 8'h22, 1'b0, 4'd0, 32'h0,
                1'b1, 8'h22, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0000_8001, 4'd5, 4'd5, 4'd0};
    vecs[2] = '{1'b1, 32'h0005_07FF, 2'd1, 8'h10, 1'b1, 4'd0, 32'h12345678,
                1'b1, 8'h10, 32'h0, 32'hDEADBEEF, 32'h0000_07FF, 4'd0, 4'd5, 4'd15};
    vecs[3] = '{1'b0, 32'h0000_0000, 2'd2, 8'hFF, 1'b1, 4'd7, 32'hA5A5A5A5,
                1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0};
    vecs[4] = '{1'b1, 32'h0078_8000, 2'd2, 8'h41, 1'b0, 4'd0, 32'h0,
                1'b1, 8'h41, 32'hA5A5A5A5, 32'h0, 32'hFFF8_8000, 4'd7, 4'd8, 4'd0};
    vecs[5] = '{1'b1, 32'h0000_0000, 2'd0, 8'h04, 1'b0, 4'd0, 32'h0,
                1'b1, 8'h04, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0};

    rst = 1'b1;
    drive(1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    d_pc = '0; d_pc4 = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    ex_stall = 1'b0; flush = 1'b0;
    tick();
    chk("reset_e_valid", 32'(e_valid), 32'h0);
    chk("reset_e_ctrl", 32'(e_ctrl), 32'h0);
    chk("reset_e_rd1", e_rd1, 32'h0);
    chk("reset_d_stall", 32'(d_stall), 32'h0);
    rst = 1'b0;

    // Single-cycle captures: bypass, zero register, immediate formats, invalid slot.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].valid, vecs[i].instr, vecs[i].ctrl, vecs[i].sel, 1'b1, 1'b1);
      d_pc = 32'h100 + 32'(i) * 4; d_pc4 = d_pc + 4;
      wb_we = vecs[i].wb_we; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
      #1 chk($sformatf("v%0d_d_stall", i), 32'(d_stall), 32'h0);
      tick();
      wb_we = 1'b0;
      chk($sformatf("v%0d_e_valid", i), 32'(e_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_e_ctrl", i), 32'(e_ctrl), 32'(vecs[i].exp_ctrl));
      chk($sformatf("v%0d_e_rd1", i), e_rd1, vecs[i].exp_rd1);
      chk($sformatf("v%0d_e_rd2", i), e_rd2, vecs[i].exp_rd2);
      chk($sformatf("v%0d_e_imm", i), e_imm, vecs[i].exp_imm);
      chk($sformatf("v%0d_e_rs1", i), 32'(e_rs1), 32'(vecs[i].exp_rs1));
      chk($sformatf("v%0d_e_rs2", i), 32'(e_rs2), 32'(vecs[i].exp_rs2));
      chk($sformatf("v%0d_e_rd", i), 32'(e_rd), 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d_e_pc", i), e_pc, 32'h100 + 32'(i) * 4);
      chk($sformatf("v%0d_e_pc4", i), e_pc4, 32'h104 + 32'(i) * 4);
    end

    // Load-use: load to r3 in EX, consumer reads rs2=3.
    drive(1'b1, 32'h0000_0030, 8'h08, 2'd0, 1'b0, 1'b0);
    tick();
    chk("lu_load_e_rd", 32'(e_rd), 32'd3);
    drive(1'b1, 32'h0003_0000, 8'h01, 2'd0, 1'b1, 1'b1);
    #1 chk("lu_d_stall", 32'(d_stall), 32'h1);
    tick();
    chk("lu_bubble_valid", 32'(e_valid), 32'h0);
    chk("lu_bubble_ctrl", 32'(e_ctrl), 32'h0);
    chk("lu_after_bubble_d_stall", 32'(d_stall), 32'h0);
    tick();
    chk("lu_capture_valid", 32'(e_valid), 32'h1);
    chk("lu_capture_ctrl", 32'(e_ctrl), 32'h01);
    chk("lu_capture_rs2", 32'(e_rs2), 32'd3);

    // Same load, consumer does not read rs2: no stall.
    drive(1'b1, 32'h0000_0030, 8'h08, 2'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0003_0000, 8'h01, 2'd0, 1'b1, 1'b0);
    #1 chk("nors2_d_stall", 32'(d_stall), 32'h0);
    tick();
    chk("nors2_e_valid", 32'(e_valid), 32'h1);

    // Load to r0 with rs1=0 consumer: no stall.
    drive(1'b1, 32'h0000_0000, 8'h08, 2'd0, 1'b0, 1'b0);
    tick();
    chk("r0load_e_ctrl", 32'(e_ctrl), 32'h08);
    drive(1'b1, 32'h0000_0000, 8'h01, 2'd0, 1'b1, 1'b1);
    #1 chk("r0load_d_stall", 32'(d_stall), 32'h0);
    tick();

    // Flush beats stall and hazard together.
    drive(1'b1, 32'h0000_0030, 8'h08, 2'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0003_0000, 8'h01, 2'd0, 1'b0, 1'b1);
    ex_stall = 1'b1;
    #1 chk("fl_pre_d_stall", 32'(d_stall), 32'h1);
    flush = 1'b1;
    #1 chk("fl_d_stall", 32'(d_stall), 32'h0);
    tick();
    flush = 1'b0; ex_stall = 1'b0;
    chk("fl_e_valid", 32'(e_valid), 32'h0);
    chk("fl_e_ctrl", 32'(e_ctrl), 32'h0);

    // EX holds under ex_stall while writeback updates r9; capture sees it.
    drive(1'b1, 32'h0000_0000, 8'h22, 2'd0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h0090_0000, 8'h11, 2'd0, 1'b1, 1'b0);
    ex_stall = 1'b1; wb_we = 1'b1; wb_rd = 4'd9; wb_data = 32'h0000_1111;
    tick();
    wb_we = 1'b0;
    chk("stall_hold_ctrl", 32'(e_ctrl), 32'h22);
    chk("stall_hold_rs1", 32'(e_rs1), 32'd0);
    ex_stall = 1'b0;
    tick();
    chk("stall_wb_rd1", e_rd1, 32'h0000_1111);
    chk("stall_wb_ctrl", 32'(e_ctrl), 32'h11);

    // Reset mid-stream while stalled with a valid instruction in EX.
    drive(1'b1, 32'h0070_0000, 8'h02, 2'd0, 1'b1, 1'b0);
    d_pc = 32'h200; d_pc4 = 32'h204;
    tick();
    chk("prerst_rd1", e_rd1, 32'hA5A5A5A5);
    ex_stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_e_valid", 32'(e_valid), 32'h0);
    chk("midrst_e_ctrl", 32'(e_ctrl), 32'h0);
    chk("midrst_e_rd1", e_rd1, 32'h0);
    chk("midrst_e_pc", e_pc, 32'h0);
    rst = 1'b0; ex_stall = 1'b0;
    tick();
    chk("postrst_e_valid", 32'(e_valid), 32'h1);
    chk("postrst_rd1", e_rd1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
